// File: rtl/match_score_pkg.sv
// Shared definitions for the match score controller: command opcodes,
// match FSM states and the cmd_data field layout.
package match_score_pkg;

  typedef enum logic [3:0] {
    OP_CLEAR    = 4'd0,
    OP_P1_GAME  = 4'd1,
    OP_P2_GAME  = 4'd2,
    OP_P1_SET   = 4'd3,
    OP_P2_SET   = 4'd4,
    OP_P1_MATCH = 4'd5,
    OP_P2_MATCH = 4'd6,
    OP_TB_START = 4'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_TIEBREAK = 2'd2,
    ST_DONE     = 2'd3
  } match_state_e;

  localparam int CMD_W      = 36;
  localparam int D_GP1_LSB  = 0;
  localparam int D_GP2_LSB  = 8;
  localparam int D_SP1_LSB  = 16;
  localparam int D_SP2_LSB  = 20;
  localparam int D_IDX_LSB  = 24;

  function automatic logic [31:0] pack_cmd_data(input logic [7:0] idx,
                                                input logic [3:0] sp2,
                                                input logic [3:0] sp1,
                                                input logic [7:0] gp2,
                                                input logic [7:0] gp1);
    logic [31:0] d;
    d = 32'd0;
    d[D_IDX_LSB +: 8] = idx;
    d[D_SP2_LSB +: 4] = sp2;
    d[D_SP1_LSB +: 4] = sp1;
    d[D_GP2_LSB +: 8] = gp2;
    d[D_GP1_LSB +: 8] = gp1;
    return d;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding pending LCD commands; head word reads as zero
// when empty so the command outputs are clean after reset.
module cmd_fifo #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_pop_s  = pop_i & ~empty_o;
  // A push into a full buffer still lands when the head leaves this cycle.
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign dout_o    = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array write
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

endmodule

// File: rtl/match_score_ctrl.sv
// Tennis-style match scorekeeper: counts games/sets from win pulses and
// queues one display command per accepted event.
module match_score_ctrl
  import match_score_pkg::*;
#(
  parameter  int SETS_TO_WIN   = 2,
  parameter  int GAMES_PER_SET = 6,
  parameter  int CMD_DEPTH     = 4,
  localparam int GW = $clog2(GAMES_PER_SET + 2),
  localparam int SW = $clog2(SETS_TO_WIN + 1),
  localparam int XW = $clog2(2 * SETS_TO_WIN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          game_win_p1,
  input  logic          game_win_p2,
  input  logic          cmd_ready,
  output logic          cmd_valid,
  output logic [3:0]    cmd_op,
  output logic [31:0]   cmd_data,
  output logic [GW-1:0] games_p1,
  output logic [GW-1:0] games_p2,
  output logic [SW-1:0] sets_p1,
  output logic [SW-1:0] sets_p2,
  output logic [XW-1:0] set_idx,
  output logic          tie_break,
  output logic          match_over,
  output logic          winner,
  output logic          overflow,
  output logic          protocol_err
);

  localparam logic [GW-1:0] G_C   = GW'(GAMES_PER_SET);
  localparam logic [GW-1:0] GM1_C = GW'(GAMES_PER_SET - 1);
  localparam logic [GW-1:0] GM2_C = GW'(GAMES_PER_SET - 2);
  localparam logic [GW-1:0] GP1_C = GW'(GAMES_PER_SET + 1);

  match_state_e  state_q, state_d;
  logic [GW-1:0] games_p1_q, games_p1_d, games_p2_q, games_p2_d;
  logic [SW-1:0] sets_p1_q, sets_p1_d, sets_p2_q, sets_p2_d;
  logic [XW-1:0] set_idx_q, set_idx_d;
  logic          tie_break_q, tie_break_d, match_over_q, match_over_d;
  logic          winner_q, winner_d, overflow_q, overflow_d, proto_q, proto_d;

  logic          event_s, p2_s, set_won_s, match_won_s, enter_tb_s;
  logic [GW-1:0] w_games_s, l_games_s, w_next_s, new_gp1_s, new_gp2_s;
  logic [SW-1:0] new_sp1_s, new_sp2_s;
  logic          push_s, fifo_full_s, fifo_empty_s, fifo_pop_s;
  cmd_op_e       push_op_s;
  logic [31:0]   push_data_s;
  logic [CMD_W-1:0] fifo_dout_s;

  // Simultaneous pulses are rejected as a protocol error, not scored.
  assign event_s     = game_win_p1 ^ game_win_p2;
  assign p2_s        = game_win_p2;
  assign w_games_s   = p2_s ? games_p2_q : games_p1_q;
  assign l_games_s   = p2_s ? games_p1_q : games_p2_q;
  assign w_next_s    = w_games_s + GW'(1);
  assign new_gp1_s   = p2_s ? games_p1_q : w_next_s;
  assign new_gp2_s   = p2_s ? w_next_s : games_p2_q;
  assign new_sp1_s   = p2_s ? sets_p1_q : sets_p1_q + SW'(1);
  assign new_sp2_s   = p2_s ? sets_p2_q + SW'(1) : sets_p2_q;
  assign match_won_s = ((p2_s ? new_sp2_s : new_sp1_s) == SW'(SETS_TO_WIN));
  assign enter_tb_s  = (w_next_s == G_C) && (l_games_s == G_C);
  assign set_won_s   = (state_q == ST_TIEBREAK)
                     || ((w_next_s == G_C) && (l_games_s <= GM2_C))
                     || ((w_next_s == GP1_C) && (l_games_s == GM1_C));

  // Match FSM next state, score updates and command generation
  always_comb begin
    state_d      = state_q;
    games_p1_d   = games_p1_q;
    games_p2_d   = games_p2_q;
    sets_p1_d    = sets_p1_q;
    sets_p2_d    = sets_p2_q;
    set_idx_d    = set_idx_q;
    tie_break_d  = tie_break_q;
    match_over_d = match_over_q;
    winner_d     = winner_q;
    push_s       = 1'b0;
    push_op_s    = OP_CLEAR;
    push_data_s  = 32'd0;
    case (state_q)
      ST_IDLE: begin
        push_s  = 1'b1;
        state_d = ST_PLAY;
      end
      ST_PLAY, ST_TIEBREAK: begin
        if (event_s) begin
          push_s = 1'b1;
          if (set_won_s) begin
            games_p1_d  = '0;
            games_p2_d  = '0;
            sets_p1_d   = new_sp1_s;
            sets_p2_d   = new_sp2_s;
            tie_break_d = 1'b0;
            push_data_s = pack_cmd_data(8'(set_idx_q), 4'(new_sp2_s), 4'(new_sp1_s),
                                        8'(new_gp2_s), 8'(new_gp1_s));
            if (match_won_s) begin
              state_d      = ST_DONE;
              match_over_d = 1'b1;
              winner_d     = p2_s;
              push_op_s    = p2_s ? OP_P2_MATCH : OP_P1_MATCH;
            end else begin
              state_d   = ST_PLAY;
              set_idx_d = set_idx_q + XW'(1);
              push_op_s = p2_s ? OP_P2_SET : OP_P1_SET;
            end
          end else begin
            games_p1_d  = new_gp1_s;
            games_p2_d  = new_gp2_s;
            push_data_s = pack_cmd_data(8'(set_idx_q), 4'(sets_p2_q), 4'(sets_p1_q),
                                        8'(new_gp2_s), 8'(new_gp1_s));
            if (enter_tb_s) begin
              state_d     = ST_TIEBREAK;
              tie_break_d = 1'b1;
              push_op_s   = OP_TB_START;
            end else begin
              push_op_s = p2_s ? OP_P2_GAME : OP_P1_GAME;
            end
          end
        end else begin
          push_s = 1'b0;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_pop_s = cmd_valid & cmd_ready;
  assign overflow_d = overflow_q | (push_s & fifo_full_s & ~fifo_pop_s);
  assign proto_d    = proto_q | (game_win_p1 & game_win_p2);

  // Score, status and FSM state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      games_p1_q   <= '0;
      games_p2_q   <= '0;
      sets_p1_q    <= '0;
      sets_p2_q    <= '0;
      set_idx_q    <= '0;
      tie_break_q  <= 1'b0;
      match_over_q <= 1'b0;
      winner_q     <= 1'b0;
      overflow_q   <= 1'b0;
      proto_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      games_p1_q   <= games_p1_d;
      games_p2_q   <= games_p2_d;
      sets_p1_q    <= sets_p1_d;
      sets_p2_q    <= sets_p2_d;
      set_idx_q    <= set_idx_d;
      tie_break_q  <= tie_break_d;
      match_over_q <= match_over_d;
      winner_q     <= winner_d;
      overflow_q   <= overflow_d;
      proto_q      <= proto_d;
    end
  end

  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .din_i   ({push_op_s, push_data_s}),
    .pop_i   (fifo_pop_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign cmd_valid    = ~fifo_empty_s;
  assign cmd_op       = fifo_dout_s[35:32];
  assign cmd_data     = fifo_dout_s[31:0];
  assign games_p1     = games_p1_q;
  assign games_p2     = games_p2_q;
  assign sets_p1      = sets_p1_q;
  assign sets_p2      = sets_p2_q;
  assign set_idx      = set_idx_q;
  assign tie_break    = tie_break_q;
  assign match_over   = match_over_q;
  assign winner       = winner_q;
  assign overflow     = overflow_q;
  assign protocol_err = proto_q;

endmodule

// File: tb/tb_match_score_ctrl.sv
// Directed bench for match_score_ctrl with default parameters; popped
// commands are captured into a queue and compared against hand-computed words.
module tb_match_score_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        game_win_p1 = 1'b0;
  logic        game_win_p2 = 1'b0;
  logic        cmd_ready = 1'b1;
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_data;
  logic [2:0]  games_p1, games_p2;
  logic [1:0]  sets_p1, sets_p2;
  logic [1:0]  set_idx;
  logic        tie_break, match_over, winner, overflow, protocol_err;

  int errors = 0;
  int checks = 0;
  logic [35:0] cap_q[$];

  always #5 clk = ~clk;

  match_score_ctrl dut (
    .clk(clk), .rst(rst), .game_win_p1(game_win_p1), .game_win_p2(game_win_p2),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .games_p1(games_p1), .games_p2(games_p2), .sets_p1(sets_p1), .sets_p2(sets_p2),
    .set_idx(set_idx), .tie_break(tie_break), .match_over(match_over), .winner(winner),
    .overflow(overflow), .protocol_err(protocol_err)
  );

  // Record every command that will be popped on the next rising edge
  always @(negedge clk) begin
    if (rst && cmd_valid && cmd_ready) cap_q.push_back({cmd_op, cmd_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic win(input logic p2);
    if (p2) game_win_p2 = 1'b1;
    else    game_win_p1 = 1'b1;
    tick(1);
    game_win_p1 = 1'b0;
    game_win_p2 = 1'b0;
  endtask

  task automatic check_next(input string tag, input logic [35:0] exp);
    logic [35:0] obs;
    obs = '1;
    if (cap_q.size() > 0) obs = cap_q.pop_front();
    check(tag, 64'(obs), 64'(exp));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({cmd_valid, cmd_op, cmd_data, games_p1, games_p2, sets_p1, sets_p2,
                set_idx, tie_break, match_over, winner, overflow, protocol_err});
  endfunction

  initial begin
    // Reset state, then the single CLEAR after release
    tick(3);
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b1;
    tick(1);
    check("clear_valid", 64'(cmd_valid), 64'd1);
    check("clear_head", 64'({cmd_op, cmd_data}), 64'd0);
    tick(1);
    check("clear_gone", 64'(cmd_valid), 64'd0);
    check_next("clear_cmd", 36'h0_0000_0000);
    check("clear_once", 64'(cap_q.size()), 64'd0);

    // Six straight P1 games take set 0
    for (int i = 0; i < 6; i++) begin
      win(1'b0);
      if (i == 0) check("first_game_head", 64'({cmd_valid, cmd_op, cmd_data}), 64'h1_1_0000_0001);
      tick(1);
    end
    for (int i = 1; i <= 5; i++) check_next("p1_game", {4'd1, 32'(i)});
    check_next("p1_set", 36'h3_0001_0006);
    check("after_set1", 64'({set_idx, sets_p1, sets_p2, games_p1, games_p2}), 64'({2'd1, 2'd1, 2'd0, 3'd0, 3'd0}));

    // Set 1: reach 5:5, then 6:5, 6:6 tie-break, P2 takes it 7:6
    for (int i = 0; i < 5; i++) begin
      win(1'b0); tick(1);
      win(1'b1); tick(1);
    end
    check("five_all", 64'({games_p1, games_p2}), 64'({3'd5, 3'd5}));
    cap_q.delete();
    win(1'b0);
    win(1'b1);
    check("tb_enter", 64'({tie_break, games_p1, games_p2}), 64'({1'b1, 3'd6, 3'd6}));
    tick(1);
    win(1'b1);
    check("tb_exit", 64'({tie_break, set_idx, sets_p1, sets_p2, games_p1, games_p2}),
          64'({1'b0, 2'd2, 2'd1, 2'd1, 3'd0, 3'd0}));
    tick(1);
    check_next("p1_six_five", 36'h1_0101_0506);
    check_next("tb_start", 36'h7_0101_0606);
    check_next("p2_set_tb", 36'h4_0111_0706);

    // Simultaneous pulses are ignored and flagged
    win(1'b0); tick(1);
    game_win_p1 = 1'b1; game_win_p2 = 1'b1;
    tick(1);
    game_win_p1 = 1'b0; game_win_p2 = 1'b0;
    check("both_pulses", 64'({protocol_err, games_p1, games_p2, cmd_valid}), 64'({1'b1, 3'd1, 3'd0, 1'b0}));

    // Reset mid-set with a command pending and an event during reset
    cmd_ready = 1'b0;
    win(1'b1);
    check("pending_before_rst", 64'(cmd_valid), 64'd1);
    cap_q.delete();
    rst = 1'b0;
    game_win_p1 = 1'b1;
    tick(1);
    game_win_p1 = 1'b0;
    check("midset_reset", all_outs(), 64'd0);
    rst = 1'b1;
    cmd_ready = 1'b1;
    tick(2);
    check_next("clear_after_rst", 36'h0_0000_0000);
    check("pending_discarded", 64'(cap_q.size()), 64'd0);

    // P1 wins 6:0 6:0, then the match is closed to further events
    for (int i = 0; i < 12; i++) begin
      win(1'b0); tick(1);
    end
    check("match_cmds", 64'(cap_q.size()), 64'd12);
    check("match_cmd", 64'(cap_q[$]), 64'h5_0102_0006);
    check("match_state", 64'({match_over, winner, set_idx, sets_p1, games_p1}), 64'({1'b1, 1'b0, 2'd1, 2'd2, 3'd0}));
    win(1'b1); tick(2);
    check("done_ignore", 64'({cap_q.size() == 12, cmd_valid, games_p2, sets_p2}), 64'({1'b1, 1'b0, 3'd0, 2'd0}));

    // Overflow: CLEAR plus three games fill the buffer, later pushes drop
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    cmd_ready = 1'b0;
    tick(1);
    cap_q.delete();
    for (int i = 0; i < 5; i++) win(1'b1);
    check("ovf_flag", 64'({overflow, games_p2}), 64'({1'b1, 3'd5}));
    win(1'b1);
    check("ovf_score", 64'({games_p2, sets_p2}), 64'({3'd0, 2'd1}));
    check("ovf_head_stable", 64'({cmd_valid, cmd_op, cmd_data}), 64'h1_0_0000_0000);
    cmd_ready = 1'b1;
    tick(6);
    check_next("ovf_q0", 36'h0_0000_0000);
    check_next("ovf_q1", 36'h2_0000_0100);
    check_next("ovf_q2", 36'h2_0000_0200);
    check_next("ovf_q3", 36'h2_0000_0300);
    check("ovf_dropped", 64'(cap_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
